// File: rtl/doe_kv_wr_seq_if.sv
// doe_kv_wr_seq_if
//   Bundles the two data paths of the key vault write sequencer.
//   - Upstream dword stream from the DOE cipher:
//       src_valid, src_data (into the sequencer), src_ready (out of it).
//   - Key vault write port:
//       kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data, kv_wr_dest_valid
//       (out of the sequencer), kv_wr_error (into it).
//   Modports:
//   - master: the sequencer's view.
//   - slave: the view of the surrounding cipher and key vault.
interface doe_kv_wr_seq_if #(
  parameter int KV_ENTRY_W = 5,
  parameter int OFFSET_W   = 4
);
  logic                  src_valid;
  logic [31:0]           src_data;
  logic                  src_ready;
  logic                  kv_wr_en;
  logic [KV_ENTRY_W-1:0] kv_wr_entry;
  logic [OFFSET_W-1:0]   kv_wr_offset;
  logic [31:0]           kv_wr_data;
  logic [5:0]            kv_wr_dest_valid;
  logic                  kv_wr_error;

  modport master (
    input  src_valid, src_data, kv_wr_error,
    output src_ready, kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data,
           kv_wr_dest_valid
  );

  modport slave (
    output src_valid, src_data, kv_wr_error,
    input  src_ready, kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data,
           kv_wr_dest_valid
  );
endinterface

// File: rtl/doe_kv_wr_seq.sv
// doe_kv_wr_seq
//   Write sequencer between the DOE de-obfuscation datapath and the key
//   vault. Each dword accepted from the cipher becomes one key vault write
//   to the latched entry, one cycle later, at an incrementing offset. When
//   the key vault rejects a write, the rest of the stream is drained without
//   being written. Completion and error are reported to the DOE controller.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   zeroize        synchronous abort and clear, highest priority
//   start          one-cycle command strobe (ignored while busy)
//   entry          destination key vault entry
//   num_dwords     transfer length, 1..MAX_DWORDS
//   dest_valid     dest-valid bits forwarded with every write
//   bus            upstream stream and key vault write port (master modport)
//   busy           command in progress
//   done           one-cycle completion pulse
//   error          one-cycle error pulse, either with done or after a
//                  rejected start
module doe_kv_wr_seq #(
  parameter int KV_ENTRY_W = 5,
  parameter int OFFSET_W   = 4,
  parameter int MAX_DWORDS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  zeroize,
  input  logic                  start,
  input  logic [KV_ENTRY_W-1:0] entry,
  input  logic [OFFSET_W:0]     num_dwords,
  input  logic [5:0]            dest_valid,
  doe_kv_wr_seq_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, WRITE, DRAIN, LAST, DONE} state_t;

  localparam logic [OFFSET_W:0] MAX_LEN = (OFFSET_W+1)'(MAX_DWORDS);

  state_t                state;
  logic [KV_ENTRY_W-1:0] entry_lat;
  logic [OFFSET_W:0]     num_lat;
  logic [5:0]            dv_lat;
  logic [OFFSET_W:0]     count;
  logic                  err_lat;

  logic                  accept;
  logic                  wr_rej;
  logic                  len_ok;
  logic [OFFSET_W:0]     cnt_acc;
  logic                  all_in;

  assign accept  = bus.src_valid & bus.src_ready;
  assign wr_rej  = bus.kv_wr_en & bus.kv_wr_error;
  assign len_ok  = (num_dwords != '0) && (num_dwords <= MAX_LEN);
  assign cnt_acc = count + {{OFFSET_W{1'b0}}, accept};
  // True once the dword accepted this cycle (if any) completes the transfer.
  assign all_in  = (cnt_acc == num_lat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      entry_lat            <= '0;
      num_lat              <= '0;
      dv_lat               <= '0;
      count                <= '0;
      err_lat              <= 1'b0;
      bus.src_ready        <= 1'b0;
      bus.kv_wr_en         <= 1'b0;
      bus.kv_wr_entry      <= '0;
      bus.kv_wr_offset     <= '0;
      bus.kv_wr_data       <= '0;
      bus.kv_wr_dest_valid <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
    end else if (zeroize) begin
      state                <= IDLE;
      entry_lat            <= '0;
      num_lat              <= '0;
      dv_lat               <= '0;
      count                <= '0;
      err_lat              <= 1'b0;
      bus.src_ready        <= 1'b0;
      bus.kv_wr_en         <= 1'b0;
      bus.kv_wr_entry      <= '0;
      bus.kv_wr_offset     <= '0;
      bus.kv_wr_data       <= '0;
      bus.kv_wr_dest_valid <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
    end else begin
      // Write fields are zero unless a write is presented this cycle, so
      // key material never lingers on the bus.
      bus.kv_wr_en         <= 1'b0;
      bus.kv_wr_entry      <= '0;
      bus.kv_wr_offset     <= '0;
      bus.kv_wr_data       <= '0;
      bus.kv_wr_dest_valid <= '0;
      done                 <= 1'b0;
      error                <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              entry_lat     <= entry;
              num_lat       <= num_dwords;
              dv_lat        <= dest_valid;
              count         <= '0;
              err_lat       <= 1'b0;
              state         <= WRITE;
              busy          <= 1'b1;
              bus.src_ready <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end

        WRITE: begin
          count <= cnt_acc;
          if (wr_rej) begin
            // Any dword accepted alongside the reject is counted, not written.
            err_lat <= 1'b1;
            if (all_in) begin
              state         <= LAST;
              bus.src_ready <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            if (accept) begin
              bus.kv_wr_en         <= 1'b1;
              bus.kv_wr_entry      <= entry_lat;
              bus.kv_wr_offset     <= count[OFFSET_W-1:0];
              bus.kv_wr_data       <= bus.src_data;
              bus.kv_wr_dest_valid <= dv_lat;
            end
            if (all_in) begin
              state         <= LAST;
              bus.src_ready <= 1'b0;
            end
          end
        end

        DRAIN: begin
          count <= cnt_acc;
          if (all_in) begin
            state         <= LAST;
            bus.src_ready <= 1'b0;
          end
        end

        LAST: begin
          // The final write (if any) is on the bus now; its response is
          // folded straight into the error pulse.
          err_lat <= err_lat | wr_rej;
          done    <= 1'b1;
          error   <= err_lat | wr_rej;
          state   <= DONE;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          bus.src_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doe_kv_wr_seq.sv
// tb_doe_kv_wr_seq
//   Randomized self-checking bench for doe_kv_wr_seq. The reference model
//   states the transfer rules directly: the sequencer is ready from the
//   cycle after start until num_dwords dwords have been taken; dword i is
//   written at offset i one cycle after it was taken, unless a reject hit
//   an earlier write; done follows the last accept by two cycles.
module tb_doe_kv_wr_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       zeroize;
  logic       start;
  logic [4:0] entry;
  logic [4:0] num_dwords;
  logic [5:0] dest_valid;
  logic       busy;
  logic       done;
  logic       error;

  doe_kv_wr_seq_if #(.KV_ENTRY_W(5), .OFFSET_W(4)) bus ();

  doe_kv_wr_seq #(.KV_ENTRY_W(5), .OFFSET_W(4), .MAX_DWORDS(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .zeroize    (zeroize),
    .start      (start),
    .entry      (entry),
    .num_dwords (num_dwords),
    .dest_valid (dest_valid),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  off;
    logic [4:0]  ent;
    logic [31:0] data;
    logic [5:0]  dv;
  } wr_t;

  wr_t         obs_w[$];
  wr_t         exp_w[$];
  logic [31:0] exp_data[$];
  int          acc_cyc[$];

  int   done_cnt  = 0;
  int   done_cyc  = 0;
  logic done_err  = 1'b0;
  int   lone_err  = 0;
  int   sec_viol  = 0;
  int   ready_err = 0;
  int   t_start   = 0;
  bit   timed_out = 1'b0;
  wr_t  mon_w;

  // Passive monitor: records every write, done/error pulses, and any
  // non-zero write field while kv_wr_en is low.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.kv_wr_en === 1'b1) begin
        mon_w.cyc  = cyc;
        mon_w.off  = bus.kv_wr_offset;
        mon_w.ent  = bus.kv_wr_entry;
        mon_w.data = bus.kv_wr_data;
        mon_w.dv   = bus.kv_wr_dest_valid;
        obs_w.push_back(mon_w);
      end else if ({bus.kv_wr_entry, bus.kv_wr_offset, bus.kv_wr_data,
                    bus.kv_wr_dest_valid} !== '0) begin
        sec_viol++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = error;
      end else if (error === 1'b1) begin
        lone_err++;
      end
    end
  end

  // Reference model: expected writes from the accepted dwords.
  function automatic void build_exp(input logic [4:0] ent, input logic [5:0] dv,
                                    input int rej_off);
    wr_t w;
    exp_w.delete();
    foreach (exp_data[i]) begin
      if (rej_off < 0 || i <= rej_off) begin
        w.cyc  = acc_cyc[i] + 1;
        w.off  = 4'(i);
        w.ent  = ent;
        w.data = exp_data[i];
        w.dv   = dv;
        exp_w.push_back(w);
      end
    end
  endfunction

  // Stimulus driver plus key vault responder. vmode: 0 valid held high,
  // 1 toggling, 2 random. rej_off: offset whose write is rejected (-1 none).
  // zero_after: zeroize once this many writes were seen (-1 none).
  // bstart_at: loop index of a stray start with another entry (-1 none).
  task automatic drive_xfer(input int n, input logic [4:0] ent, input logic [5:0] dv,
                            input int vmode, input int rej_off, input int zero_after,
                            input int bstart_at);
    int wcount = 0;
    bit v;
    bit exp_ready;
    obs_w.delete();
    exp_data.delete();
    acc_cyc.delete();
    done_cnt  = 0;
    lone_err  = 0;
    ready_err = 0;
    timed_out = 1'b1;
    @(negedge clk);
    start      = 1'b1;
    entry      = ent;
    num_dwords = 5'(n);
    dest_valid = dv;
    t_start    = cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start      = 1'b0;
      entry      = '0;
      num_dwords = '0;
      dest_valid = '0;
      exp_ready  = (exp_data.size() < n);
      if (bus.src_ready !== exp_ready) ready_err++;
      if (bus.kv_wr_en === 1'b1) wcount++;
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.kv_wr_error = (rej_off >= 0) && (bus.kv_wr_en === 1'b1) &&
                        (int'(bus.kv_wr_offset) == rej_off);
      if (zero_after > 0 && wcount == zero_after) begin
        zeroize         = 1'b1;
        bus.src_valid   = 1'b0;
        bus.kv_wr_error = 1'b0;
        timed_out       = 1'b0;
        break;
      end
      bus.src_valid = v;
      bus.src_data  = $urandom;
      if (v && exp_ready) begin
        exp_data.push_back(bus.src_data);
        acc_cyc.push_back(cyc);
      end
      if (k == bstart_at) begin
        start      = 1'b1;
        entry      = ~ent;
        num_dwords = 5'd3;
        dest_valid = ~dv;
      end
    end
    bus.src_valid   = 1'b0;
    bus.kv_wr_error = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    zeroize = 1'b0;
    start = 1'b0;
    entry = '0;
    num_dwords = '0;
    dest_valid = '0;
    bus.src_valid = 1'b0;
    bus.src_data = '0;
    bus.kv_wr_error = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.src_ready, bus.kv_wr_en, bus.kv_wr_entry, bus.kv_wr_offset, bus.kv_wr_data,
         bus.kv_wr_dest_valid, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_in: got rdy=%b en=%b busy=%b done=%b err=%b, want all 0",
               bus.src_ready, bus.kv_wr_en, busy, done, error);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.src_ready, bus.kv_wr_en, bus.kv_wr_entry, bus.kv_wr_offset, bus.kv_wr_data,
         bus.kv_wr_dest_valid, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got rdy=%b en=%b busy=%b done=%b err=%b, want all 0",
               bus.src_ready, bus.kv_wr_en, busy, done, error);
    end
  endtask

  task automatic test_min_len();
    drive_xfer(1, 5'd3, 6'h15, 0, -1, -1, -1);
    build_exp(5'd3, 6'h15, -1);
    n_checks++;
    if (timed_out || acc_cyc.size() != 1 || acc_cyc[0] != t_start + 1) begin
      n_fail++;
      $display("FAIL min_accept: got n=%0d cyc=%0d, want n=1 cyc=%0d",
               acc_cyc.size(), acc_cyc[0], t_start + 1);
    end
    n_checks++;
    if (obs_w.size() != 1 || obs_w[0] !== exp_w[0]) begin
      n_fail++;
      $display("FAIL min_write: got n=%0d w=%h, want n=1 w=%h", obs_w.size(), obs_w[0], exp_w[0]);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != t_start + 3 || done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL min_done: got cnt=%0d cyc=%0d err=%b, want cnt=1 cyc=%0d err=0",
               done_cnt, done_cyc, done_err, t_start + 3);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL min_busy_clear: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_full16();
    drive_xfer(16, 5'd7, 6'h2a, 0, -1, -1, -1);
    build_exp(5'd7, 6'h2a, -1);
    n_checks++;
    if (timed_out || acc_cyc.size() != 16 || acc_cyc[$] - acc_cyc[0] != 15) begin
      n_fail++;
      $display("FAIL full16_accepts: got n=%0d span=%0d, want n=16 span=15",
               acc_cyc.size(), acc_cyc[$] - acc_cyc[0]);
    end
    n_checks++;
    if (ready_err != 0) begin
      n_fail++;
      $display("FAIL full16_ready: got %0d src_ready mismatches, want 0", ready_err);
    end
    n_checks++;
    if (obs_w.size() != 16) begin
      n_fail++;
      $display("FAIL full16_count: got %0d writes, want 16", obs_w.size());
    end
    foreach (exp_w[i]) begin
      if (i < obs_w.size()) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL full16_write%0d: got %h, want %h", i, obs_w[i], exp_w[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != acc_cyc[$] + 2 || done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full16_done: got cnt=%0d cyc=%0d err=%b, want cnt=1 cyc=%0d err=0",
               done_cnt, done_cyc, done_err, acc_cyc[$] + 2);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full16_busy_clear: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_toggle();
    drive_xfer(4, 5'd12, 6'h3f, 1, -1, -1, -1);
    build_exp(5'd12, 6'h3f, -1);
    n_checks++;
    if (timed_out || ready_err != 0 || obs_w.size() != 4) begin
      n_fail++;
      $display("FAIL toggle_count: got writes=%0d ready_err=%0d to=%b, want 4/0/0",
               obs_w.size(), ready_err, timed_out);
    end
    foreach (exp_w[i]) begin
      if (i < obs_w.size()) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL toggle_write%0d: got %h, want %h", i, obs_w[i], exp_w[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != acc_cyc[$] + 2 || done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_done: got cnt=%0d cyc=%0d err=%b, want cnt=1 cyc=%0d err=0",
               done_cnt, done_cyc, done_err, acc_cyc[$] + 2);
    end
  endtask

  task automatic test_reject();
    drive_xfer(8, 5'd20, 6'h01, 0, 1, -1, -1);
    build_exp(5'd20, 6'h01, 1);
    n_checks++;
    if (timed_out || acc_cyc.size() != 8 || ready_err != 0) begin
      n_fail++;
      $display("FAIL reject_accepts: got n=%0d ready_err=%0d to=%b, want 8/0/0",
               acc_cyc.size(), ready_err, timed_out);
    end
    n_checks++;
    if (obs_w.size() != 2) begin
      n_fail++;
      $display("FAIL reject_count: got %0d writes, want 2", obs_w.size());
    end
    foreach (exp_w[i]) begin
      if (i < obs_w.size()) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL reject_write%0d: got %h, want %h", i, obs_w[i], exp_w[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != acc_cyc[$] + 2 || done_err !== 1'b1 || lone_err != 0) begin
      n_fail++;
      $display("FAIL reject_done: got cnt=%0d cyc=%0d err=%b lone=%0d, want cnt=1 cyc=%0d err=1 lone=0",
               done_cnt, done_cyc, done_err, lone_err, acc_cyc[$] + 2);
    end
  endtask

  task automatic test_illegal_len();
    logic [4:0] lens[3];
    lens[0] = 5'd0;
    lens[1] = 5'd17;
    lens[2] = 5'd31;
    obs_w.delete();
    foreach (lens[i]) begin
      @(negedge clk);
      start = 1'b1;
      entry = 5'd5;
      num_dwords = lens[i];
      dest_valid = 6'h3f;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bus.src_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_%0d_pulse: got err=%b done=%b busy=%b rdy=%b, want 1/0/0/0",
                 lens[i], error, done, busy, bus.src_ready);
      end
      @(negedge clk);
      n_checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_%0d_after: got err=%b busy=%b, want 0/0", lens[i], error, busy);
      end
    end
    n_checks++;
    if (obs_w.size() != 0) begin
      n_fail++;
      $display("FAIL illegal_writes: got %0d writes, want 0", obs_w.size());
    end
  endtask

  task automatic test_zeroize();
    drive_xfer(10, 5'd9, 6'h22, 0, -1, 3, -1);
    @(negedge clk);
    zeroize = 1'b0;
    n_checks++;
    if ({bus.src_ready, bus.kv_wr_en, bus.kv_wr_entry, bus.kv_wr_offset, bus.kv_wr_data,
         bus.kv_wr_dest_valid, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL zeroize_clear: got rdy=%b en=%b busy=%b done=%b err=%b, want all 0",
               bus.src_ready, bus.kv_wr_en, busy, done, error);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt != 0 || lone_err != 0 || busy !== 1'b0 || obs_w.size() != 3) begin
      n_fail++;
      $display("FAIL zeroize_quiet: got done=%0d err=%0d busy=%b writes=%0d, want 0/0/0/3",
               done_cnt, lone_err, busy, obs_w.size());
    end
    drive_xfer(5, 5'd11, 6'h0c, 2, -1, -1, -1);
    build_exp(5'd11, 6'h0c, -1);
    n_checks++;
    if (timed_out || ready_err != 0 || obs_w.size() != 5) begin
      n_fail++;
      $display("FAIL zeroize_rerun_count: got writes=%0d ready_err=%0d to=%b, want 5/0/0",
               obs_w.size(), ready_err, timed_out);
    end
    foreach (exp_w[i]) begin
      if (i < obs_w.size()) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL zeroize_rerun_write%0d: got %h, want %h", i, obs_w[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    drive_xfer(6, 5'd14, 6'h30, 0, -1, -1, 2);
    build_exp(5'd14, 6'h30, -1);
    n_checks++;
    if (timed_out || obs_w.size() != 6 || done_cnt != 1 || done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_run: got writes=%0d done=%0d err=%b to=%b, want 6/1/0/0",
               obs_w.size(), done_cnt, done_err, timed_out);
    end
    foreach (exp_w[i]) begin
      if (i < obs_w.size()) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL busy_start_write%0d: got %h, want %h", i, obs_w[i], exp_w[i]);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || obs_w.size() != 6) begin
      n_fail++;
      $display("FAIL busy_start_after: got busy=%b writes=%0d, want 0/6", busy, obs_w.size());
    end
  endtask

  task automatic test_random();
    int n;
    int rej;
    logic [4:0] ent;
    logic [5:0] dv;
    int bad;
    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(1, 16);
      rej = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      ent = 5'($urandom);
      dv  = 6'($urandom);
      drive_xfer(n, ent, dv, 2, rej, -1, -1);
      build_exp(ent, dv, rej);
      n_checks++;
      if (timed_out || acc_cyc.size() != n || ready_err != 0) begin
        n_fail++;
        $display("FAIL random%0d_accepts: got n=%0d ready_err=%0d to=%b, want %0d/0/0",
                 it, acc_cyc.size(), ready_err, timed_out, n);
      end
      bad = 0;
      foreach (exp_w[i]) if (i >= obs_w.size() || obs_w[i] !== exp_w[i]) bad++;
      n_checks++;
      if (obs_w.size() != exp_w.size() || bad != 0) begin
        n_fail++;
        $display("FAIL random%0d_writes: got %0d writes (%0d wrong), want %0d",
                 it, obs_w.size(), bad, exp_w.size());
      end
      n_checks++;
      if (done_cnt != 1 || done_cyc != acc_cyc[$] + 2 || done_err !== 1'(rej >= 0)) begin
        n_fail++;
        $display("FAIL random%0d_done: got cnt=%0d cyc=%0d err=%b, want cnt=1 cyc=%0d err=%b",
                 it, done_cnt, done_cyc, done_err, acc_cyc[$] + 2, rej >= 0);
      end
    end
  endtask

  task automatic test_idle_bus_zero();
    n_checks++;
    if (sec_viol != 0) begin
      n_fail++;
      $display("FAIL idle_bus_zero: got %0d cycles with data on idle bus, want 0", sec_viol);
    end
  endtask

  initial begin
    test_reset();
    test_min_len();
    test_full16();
    test_toggle();
    test_reject();
    test_illegal_len();
    test_zeroize();
    test_busy_start();
    test_random();
    test_idle_bus_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
